// File: rtl/alu_req_issuer.sv
// -----------------------------------------------------------------------------
// alu_req_issuer
//
// Purpose: issues one command at a time to a cv32e40p-style ALU. It registers
// the command, keeps the ALU inputs stable while the op runs (including
// multi-cycle div/rem), captures the result, and presents it on a
// valid/ready response port. A new command is accepted only after the
// previous response has been consumed.
//
// Optional feature (macro ALU_ISSUER_TIMEOUT_EN): an EXEC watchdog. If
// alu_ready stays low for 64 EXEC cycles, the op is abandoned and a response
// with rsp_timeout=1 and zero result/compare is returned. In the default
// build (macro undefined) there is no watchdog, EXEC waits indefinitely and
// rsp_timeout is tied to 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_operator, cmd_operand_a/b/c, cmd_vector_mode   command fields
//   alu_enable, alu_operator, alu_operand_a/b/c, alu_vector_mode, alu_ex_ready
//                              ALU drive (fields held stable through EXEC)
//   alu_bmask_a/b, alu_imm_vec_ext, alu_is_clpx, alu_is_subrot, alu_clpx_shift
//                              unused ALU controls, tied to 0
//   alu_result, alu_comparison_result, alu_ready      ALU results
//   rsp_valid / rsp_ready      response handshake
//   rsp_result, rsp_cmp, rsp_timeout                  response fields
//
// The cv32e40p_pkg below carries only the opcode subset this block and its
// bench use; when integrating with the full core, drop it in favour of the
// core's own package.
// -----------------------------------------------------------------------------
package cv32e40p_pkg;
    typedef enum logic [6:0] {
        ALU_SLTS = 7'b0000010,
        ALU_SLTU = 7'b0000011,
        ALU_ADD  = 7'b0011000,
        ALU_SUB  = 7'b0011001,
        ALU_DIVU = 7'b0110000,
        ALU_DIV  = 7'b0110001,
        ALU_REMU = 7'b0110010,
        ALU_REM  = 7'b0110011
    } alu_opcode_e;
endpackage

// state | meaning
// IDLE  | waiting for a command; cmd_ready high (after first post-reset edge)
// EXEC  | command driven to ALU with alu_enable; waiting for alu_ready
// RESP  | result held on rsp_*; waiting for rsp_ready
module alu_req_issuer
    import cv32e40p_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  alu_opcode_e cmd_operator,
    input  logic [31:0] cmd_operand_a,
    input  logic [31:0] cmd_operand_b,
    input  logic [31:0] cmd_operand_c,
    input  logic [1:0]  cmd_vector_mode,

    output logic        alu_enable,
    output alu_opcode_e alu_operator,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [31:0] alu_operand_c,
    output logic [1:0]  alu_vector_mode,
    output logic        alu_ex_ready,
    output logic [4:0]  alu_bmask_a,
    output logic [4:0]  alu_bmask_b,
    output logic [1:0]  alu_imm_vec_ext,
    output logic        alu_is_clpx,
    output logic        alu_is_subrot,
    output logic [1:0]  alu_clpx_shift,

    input  logic [31:0] alu_result,
    input  logic        alu_comparison_result,
    input  logic        alu_ready,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cmp,
    output logic        rsp_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_cmd_ready;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_alu_enable;
    logic        w_ex_ready;
    logic        w_rsp_valid;

    alu_opcode_e r_op;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_op_c;
    logic [1:0]  r_vec_mode;
    logic [31:0] r_result;
    logic        r_cmp;

    // cmd_ready is a flop so that it is low throughout reset, rises on the
    // first edge after release, and cannot be asserted in the RESP cycle that
    // hands over to IDLE.
    assign w_accept = cmd_valid && r_cmd_ready;

`ifdef ALU_ISSUER_TIMEOUT_EN
    logic [5:0] r_wd_cnt;
    logic       r_timeout;

    assign w_timeout = (r_state == ST_EXEC) && !alu_ready && (r_wd_cnt == 6'd63);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= 6'd0;
        end else if (w_accept) begin
            r_wd_cnt <= 6'd0;
        end else if ((r_state == ST_EXEC) && !alu_ready) begin
            r_wd_cnt <= r_wd_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_capture) begin
            // alu_ready in the final watchdog cycle counts as normal completion
            r_timeout <= !alu_ready;
        end
    end

    assign rsp_timeout = r_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_alu_enable = 1'b0;
        w_ex_ready   = 1'b0;
        w_rsp_valid  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_alu_enable = 1'b1;
                if (alu_ready) begin
                    w_ex_ready  = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= alu_opcode_e'(7'd0);
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_op_c     <= 32'd0;
            r_vec_mode <= 2'd0;
        end else if (w_accept) begin
            r_op       <= cmd_operator;
            r_op_a     <= cmd_operand_a;
            r_op_b     <= cmd_operand_b;
            r_op_c     <= cmd_operand_c;
            r_vec_mode <= cmd_vector_mode;
        end
    end

    // A watchdog capture (alu_ready low) returns zero result and compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 32'd0;
            r_cmp    <= 1'b0;
        end else if (w_capture) begin
            r_result <= alu_ready ? alu_result : 32'd0;
            r_cmp    <= alu_ready & alu_comparison_result;
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign alu_enable      = w_alu_enable;
    assign alu_ex_ready    = w_ex_ready;
    assign alu_operator    = r_op;
    assign alu_operand_a   = r_op_a;
    assign alu_operand_b   = r_op_b;
    assign alu_operand_c   = r_op_c;
    assign alu_vector_mode = r_vec_mode;
    assign alu_bmask_a     = 5'd0;
    assign alu_bmask_b     = 5'd0;
    assign alu_imm_vec_ext = 2'd0;
    assign alu_is_clpx     = 1'b0;
    assign alu_is_subrot   = 1'b0;
    assign alu_clpx_shift  = 2'd0;
    assign rsp_valid       = w_rsp_valid;
    assign rsp_result      = r_result;
    assign rsp_cmp         = r_cmp;

endmodule

// File: doc/alu_req_issuer.md
ALU_REQ_ISSUER -- requirements
Module: alu_req_issuer

Interface
REQ-001 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-004 SHALL have cmd_operator in alu_opcode_e (cv32e40p_pkg, 7b); cmd_operand_a/b/c in 32 each; cmd_vector_mode in 2.
REQ-005 SHALL have ALU-side outputs: alu_enable 1, alu_operator alu_opcode_e, alu_operand_a/b/c 32, alu_vector_mode 2, alu_ex_ready 1.
REQ-006 SHALL drive alu_bmask_a/b (5b), alu_imm_vec_ext (2b), alu_is_clpx, alu_is_subrot, alu_clpx_shift (2b) as constant 0.
REQ-007 SHALL have ALU-side inputs: alu_result 32, alu_comparison_result 1, alu_ready 1.
REQ-008 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_result out 32, rsp_cmp out 1, rsp_timeout out 1.

Function
REQ-009 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-010 SHALL assert cmd_ready only in IDLE; cmd accepted when cmd_valid && cmd_ready.
REQ-011 SHALL register all command fields at accept; hold them stable on alu_* until EXEC exits.
REQ-012 SHALL transition IDLE->EXEC on accept.
REQ-013 SHALL assert alu_enable in every EXEC cycle, deassert in IDLE and RESP.
REQ-014 SHALL, in EXEC cycle with alu_ready=1: capture alu_result/alu_comparison_result, assert alu_ex_ready that cycle only, go to RESP.
REQ-015 SHALL keep alu_ex_ready 0 in all other cycles.
REQ-016 SHALL hold in EXEC indefinitely while alu_ready=0 (multi-cycle div/rem), subject to REQ-025.
REQ-017 SHALL assert rsp_valid only in RESP; rsp_result/rsp_cmp/rsp_timeout stable while rsp_valid && !rsp_ready.
REQ-018 SHALL transition RESP->IDLE on rsp_ready; no new command accepted in that cycle (cmd_ready from state register).
REQ-019 Latency: accept at cycle N, single-cycle op (alu_ready=1 at N+1) -> rsp_valid at N+2; max throughput one op per 3 cycles.
REQ-020 SHALL never issue a second op before the previous response is consumed.

Reset
REQ-021 SHALL on rst_n=0 immediately force IDLE, irrespective of state (incl. mid-EXEC).
REQ-022 SHALL reset all outputs to 0: cmd_ready 0 during reset then 1 first cycle after release; alu_enable 0, alu_ex_ready 0, rsp_valid 0, rsp_result 0, rsp_cmp 0, rsp_timeout 0, registered operands/operator/vector_mode 0.
REQ-023 SHALL discard any in-flight op on reset; no response produced for it.

Configuration
REQ-024 Macro ALU_ISSUER_TIMEOUT_EN SHALL control an EXEC watchdog.
REQ-025 With macro: 6-bit counter cleared on IDLE->EXEC, increments each EXEC cycle with alu_ready=0; at count 63 with alu_ready=0, SHALL leave EXEC to RESP with rsp_timeout=1, rsp_result=0, rsp_cmp=0, alu_ex_ready=0; alu_ready=1 in that same cycle wins (normal completion).
REQ-026 Without macro: no counter, rsp_timeout tied 0, EXEC waits unbounded.

Verification
REQ-027 ADD a=5,b=3, alu_ready=1 combinational -> rsp_result=8, rsp_cmp per ALU, rsp_valid at N+2, alu_ex_ready pulse one cycle at N+1.
REQ-028 SLTS a=0xFFFFFFFF,b=1 -> rsp_cmp=1; operands held on alu_* throughout EXEC.
REQ-029 DIVU a=100,b=7, alu_ready after 34 cycles -> alu_enable high all 34 cycles, rsp_result=14, cmd_ready 0 until RESP->IDLE.
REQ-030 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_result stable, cmd_ready 0, alu_enable 0; released -> IDLE next cycle.
REQ-031 With ALU_ISSUER_TIMEOUT_EN, alu_ready stuck 0 -> RESP after 64 EXEC cycles, rsp_timeout=1, rsp_result=0; without macro -> still EXEC after 1000 cycles.
REQ-032 rst_n pulsed low mid-EXEC of DIV -> alu_enable 0 and rsp_valid 0 asynchronously, cmd_ready 1 after release, next ADD 2+2 -> rsp_result=4.
